// File: rtl/cdc_handshake_tx.sv
// Source-side four-phase req/ack CDC sender; optional handshake watchdog under CDC_TX_TIMEOUT_EN.
// Latency: req_o rises one edge after accept; ack_i is seen SYNC_STAGES edges later, acted on the edge after.
// Backpressure: ready_o low while a handshake is open or a stale ack is still high; valid_i is ignored then.
module cdc_handshake_tx #(
    parameter int DATA_WIDTH     = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  req_o,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    req_q;
    logic                    req_d;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    capture;
    logic                    to_hit;
    logic [SYNC_STAGES-1:0]  ack_sync;
    logic                    ack_s;

    // ack_i is asynchronous; only the last flop of this chain is ever looked at.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_i};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

`ifdef CDC_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             timeout_q;

    // Fires on the edge where the count would reach the limit, so the abort lands TIMEOUT_CYCLES edges after accept.
    assign to_hit = (state_q != IDLE) && (to_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (capture) begin
                to_cnt <= '0;
            end else if ((state_q != IDLE) && (to_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (to_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign to_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        capture = 1'b0;
        ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = ~ack_s;
                if (valid_i && !ack_s) begin
                    capture = 1'b1;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        if (to_hit) begin
            req_d   = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            if (capture) begin
                data_q <= data_i;
            end
        end
    end

    assign data_o = data_q;
    assign req_o  = req_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: loopback transfers, stale ack, reset abort and watchdog.
module tb_cdc_handshake_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_o;
    logic        req_o;
    logic        ack_i;
    logic        busy_o;
    logic        timeout_o;

    logic        loopback;
    logic        ack_force;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    assign ack_i = loopback ? req_o : ack_force;

    always #5 clk = ~clk;

    cdc_handshake_tx #(
        .DATA_WIDTH     (32),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_o    (data_o),
        .req_o     (req_o),
        .ack_i     (ack_i),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int          acc;
        int          last_acc;
        int          viol;
        logic        will;
        logic        req_prev;
        logic [31:0] data_prev;

        reset     = 1'b1;
        valid_i   = 1'b0;
        data_i    = '0;
        loopback  = 1'b1;
        ack_force = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_req",     32'(req_o),     32'd0);
        check("rst_data",    data_o,         32'd0);
        check("rst_ready",   32'(ready_o),   32'd1);
        check("rst_busy",    32'(busy_o),    32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);

        // single word in loopback: accept on edge N
        valid_i = 1'b1;
        data_i  = 32'hDEADBEEF;
        tick();
        valid_i = 1'b0;
        data_i  = 32'h12345678;
        check("sw_req_rise",  32'(req_o),   32'd1);
        check("sw_data",      data_o,       32'hDEADBEEF);
        check("sw_busy",      32'(busy_o),  32'd1);
        check("sw_ready_lo",  32'(ready_o), 32'd0);
        tick();
        tick();
        check("sw_req_n2",    32'(req_o),   32'd1);
        tick();
        check("sw_req_fall",  32'(req_o),   32'd0);
        check("sw_busy_n3",   32'(busy_o),  32'd1);
        check("sw_data_n3",   data_o,       32'hDEADBEEF);
        tick();
        tick();
        check("sw_ready_n5",  32'(ready_o), 32'd0);
        tick();
        check("sw_ready_n6",  32'(ready_o), 32'd1);
        check("sw_busy_n6",   32'(busy_o),  32'd0);
        check("sw_data_n6",   data_o,       32'hDEADBEEF);

        // back-to-back words 1,2,3 with valid held
        valid_i   = 1'b1;
        data_i    = 32'd1;
        acc       = 0;
        last_acc  = 0;
        viol      = 0;
        req_prev  = req_o;
        data_prev = data_o;
        for (int i = 0; i < 40 && acc < 3; i++) begin
            will = valid_i && ready_o;
            tick();
            if (req_prev && req_o && (data_o != data_prev)) viol++;
            req_prev  = req_o;
            data_prev = data_o;
            if (will) begin
                acc++;
                check("b2b_data", data_o, 32'(acc));
                if (acc > 1) check("b2b_period", 32'(cyc - last_acc), 32'd7);
                last_acc = cyc;
                if (acc == 3) valid_i = 1'b0;
                else data_i = 32'(acc + 1);
            end
        end
        check("b2b_count", 32'(acc), 32'd3);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (req_prev && req_o && (data_o != data_prev)) viol++;
            req_prev  = req_o;
            data_prev = data_o;
        end
        check("b2b_stable", 32'(viol), 32'd0);
        check("b2b_idle",   32'(ready_o), 32'd1);

        // stale ack held high in IDLE
        loopback  = 1'b0;
        ack_force = 1'b1;
        tick();
        tick();
        tick();
        check("stale_ready", 32'(ready_o), 32'd0);
        valid_i = 1'b1;
        data_i  = 32'hA5A5A5A5;
        tick();
        check("stale_nocap_req",  32'(req_o),  32'd0);
        check("stale_nocap_busy", 32'(busy_o), 32'd0);
        tick();
        ack_force = 1'b0;
        tick();
        check("stale_ready_s1", 32'(ready_o), 32'd0);
        tick();
        check("stale_ready_s2", 32'(ready_o), 32'd1);
        check("stale_req_s2",   32'(req_o),   32'd0);
        tick();
        valid_i = 1'b0;
        check("stale_cap_req",  32'(req_o),  32'd1);
        check("stale_cap_data", data_o,      32'hA5A5A5A5);

        // reset while in REQ, with valid also high during reset
        tick();
        check("mid_req_held", 32'(req_o), 32'd1);
        reset   = 1'b1;
        valid_i = 1'b1;
        data_i  = 32'hFFFFFFFF;
        tick();
        check("mid_rst_req",   32'(req_o),   32'd0);
        check("mid_rst_busy",  32'(busy_o),  32'd0);
        check("mid_rst_data",  data_o,       32'd0);
        check("mid_rst_ready", 32'(ready_o), 32'd1);
        reset   = 1'b0;
        valid_i = 1'b0;
        tick();
        check("post_rst_req",  32'(req_o),  32'd0);

        // ack stuck low after an accept
        valid_i = 1'b1;
        data_i  = 32'hCAFEF00D;
        tick();
        valid_i = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
        repeat (15) tick();
        check("to_pre_flag", 32'(timeout_o), 32'd0);
        check("to_pre_req",  32'(req_o),     32'd1);
        tick();
        check("to_flag",     32'(timeout_o), 32'd1);
        check("to_req",      32'(req_o),     32'd0);
        check("to_busy",     32'(busy_o),    32'd0);
        repeat (5) tick();
        check("to_sticky",   32'(timeout_o), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("to_rst_flag", 32'(timeout_o), 32'd0);
`else
        repeat (40) tick();
        check("stuck_busy",  32'(busy_o),    32'd1);
        check("stuck_req",   32'(req_o),     32'd1);
        check("stuck_flag",  32'(timeout_o), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("stuck_rst_busy", 32'(busy_o), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
